// File: rtl/uart_echo_fifo_pkg.sv
// Shared constants, state encodings and byte helpers for the UART echo buffer.
// Optional uppercase conversion is selected in the top by UART_ECHO_UPPERCASE_EN.
package uart_echo_fifo_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] ASCII_LO_A = 8'h61;
   localparam logic [BYTE_W-1:0] ASCII_LO_Z = 8'h7A;
   localparam logic [BYTE_W-1:0] CASE_OFS   = 8'h20;

   typedef enum logic {
      I_IDLE,
      I_WAIT
   } ingest_e;

   typedef enum logic [1:0] {
      E_IDLE,
      E_WAIT_BUSY,
      E_WAIT_DONE
   } egress_e;

   function automatic logic [BYTE_W-1:0] to_upper(
      input logic [BYTE_W-1:0] b
   );
      if (b >= ASCII_LO_A && b <= ASCII_LO_Z) begin
         return b - CASE_OFS;
      end
      return b;
   endfunction

endpackage

// File: rtl/uart_echo_fifo_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and an occupancy count
// one bit wider than the pointers so a full FIFO reads DEPTH.
module uart_echo_fifo_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam int          DEPTH   = 2 ** AW;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign rd_data = mem[rd_ptr];
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);

   // Byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo-path byte buffer: acks uart_receive bytes into a FIFO and paces them
// out to uart_transmitter on busy. Define UART_ECHO_UPPERCASE_EN to uppercase a..z.
module uart_echo_fifo
   import uart_echo_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2   = 4,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BYTE_W-1:0]     rx_data,
   input  logic                  rx_ready,
   output logic                  rx_ack,
   output logic [BYTE_W-1:0]     tx_data,
   output logic                  tx_send,
   input  logic                  tx_busy,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow
);

   localparam int          TW   = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(BUSY_TIMEOUT);

   ingest_e i_state;
   egress_e e_state;

   logic [TW-1:0]     timer;
   logic [BYTE_W-1:0] rd_data;
   logic [BYTE_W-1:0] tx_next;
   logic              full;
   logic              empty;
   logic              take;
   logic              wr_en;
   logic              pop;

   assign take  = (i_state == I_IDLE) && rx_ready;
   assign wr_en = take && !full;
   assign pop   = (e_state == E_IDLE) && !empty && !tx_busy;

`ifdef UART_ECHO_UPPERCASE_EN
   assign tx_next = to_upper(rd_data);
`else
   assign tx_next = rd_data;
`endif

   uart_echo_fifo_fifo #(
      .W  (BYTE_W),
      .AW (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (rx_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Ingest: take one byte per rx_ready assertion, ack it, wait for release.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_state  <= I_IDLE;
         rx_ack   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rx_ack <= 1'b0;
         unique case (i_state)
            I_IDLE: begin
               if (rx_ready) begin
                  rx_ack  <= 1'b1;
                  i_state <= I_WAIT;
                  if (full) begin
                     overflow <= 1'b1;
                  end
               end
            end
            I_WAIT: begin
               if (!rx_ready) begin
                  i_state <= I_IDLE;
               end
            end
            default: i_state <= I_IDLE;
         endcase
      end
   end

   // Egress: pop to tx_data with a send pulse, then wait out the TX frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_state <= E_IDLE;
         tx_send <= 1'b0;
         tx_data <= '0;
         timer   <= '0;
      end else begin
         tx_send <= 1'b0;
         unique case (e_state)
            E_IDLE: begin
               if (pop) begin
                  tx_data <= tx_next;
                  tx_send <= 1'b1;
                  timer   <= '0;
                  e_state <= E_WAIT_BUSY;
               end
            end
            E_WAIT_BUSY: begin
               if (tx_busy) begin
                  e_state <= E_WAIT_DONE;
               end else if (timer == TMAX) begin
                  e_state <= E_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            E_WAIT_DONE: begin
               if (!tx_busy) begin
                  e_state <= E_IDLE;
               end
            end
            default: e_state <= E_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: queue-based reference model compared every cycle,
// plus directed checks with literal expectations.
module tb_uart_echo_fifo;

   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int BT    = 15;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic [7:0]    rx_data  = 8'h00;
   logic          rx_ready = 1'b0;
   logic          rx_ack;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          tx_busy  = 1'b0;
   logic [DL:0]   count;
   logic          overflow;

   always #5 clk = ~clk;

   uart_echo_fifo #(
      .DEPTH_LOG2   (DL),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .rx_ack   (rx_ack),
      .tx_data  (tx_data),
      .tx_send  (tx_send),
      .tx_busy  (tx_busy),
      .count    (count),
      .overflow (overflow)
   );

   int vecs = 0;
   int miss = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   function automatic logic [7:0] xf(input logic [7:0] b);
`ifdef UART_ECHO_UPPERCASE_EN
      return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
      return b;
`endif
   endfunction

   // Transmitter emulation: 0 = forced busy level, 1 = frame model, 2 = tied low
   int   bmode  = 2;
   logic bforce = 1'b0;
   logic pend   = 1'b0;
   int   dly    = 0;
   int   rem    = 0;

   always @(negedge clk) begin
      if (bmode == 0) begin
         tx_busy <= bforce;
      end else if (bmode == 2) begin
         tx_busy <= 1'b0;
      end else begin
         if (tx_send === 1'b1) begin
            pend <= 1'b1;
            dly  <= ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            rem  <= $urandom_range(3, 12);
         end else if (pend) begin
            if (dly == 0) begin
               tx_busy <= 1'b1;
               pend    <= 1'b0;
            end else begin
               dly <= dly - 1;
            end
         end else if (tx_busy) begin
            if (rem <= 1) tx_busy <= 1'b0;
            else rem <= rem - 1;
         end
      end
   end

   // Inputs as seen by the DUT at each rising edge
   logic       s_reset = 1'b1;
   logic       s_ready = 1'b0;
   logic [7:0] s_data  = 8'h00;
   logic       s_busy  = 1'b0;

   always @(posedge clk) begin
      s_reset <= reset;
      s_ready <= rx_ready;
      s_data  <= rx_data;
      s_busy  <= tx_busy;
   end

   // Reference model state
   logic [7:0] mq[$];
   logic [7:0] sent_q[$];
   int         scyc[$];
   logic       m_ack  = 1'b0;
   logic       m_send = 1'b0;
   logic [7:0] m_txd  = 8'h00;
   logic       m_ovf  = 1'b0;
   bit         held   = 1'b0;
   int         eg     = 0;
   int         since  = 0;
   int         cyc    = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (s_reset) begin
            mq.delete();
            m_ack  = 1'b0;
            m_send = 1'b0;
            m_txd  = 8'h00;
            m_ovf  = 1'b0;
            held   = 1'b0;
            eg     = 0;
            since  = 0;
         end else begin
            int n0;
            n0     = mq.size();
            m_ack  = 1'b0;
            m_send = 1'b0;
            if (eg == 0) begin
               if (n0 > 0 && !s_busy) begin
                  m_txd  = xf(mq.pop_front());
                  m_send = 1'b1;
                  eg     = 1;
                  since  = 0;
               end
            end else if (eg == 1) begin
               since++;
               if (s_busy) eg = 2;
               else if (since > BT) eg = 0;
            end else if (!s_busy) begin
               eg = 0;
            end
            if (!held && s_ready) begin
               m_ack = 1'b1;
               held  = 1'b1;
               if (n0 < DEPTH) mq.push_back(s_data);
               else m_ovf = 1'b1;
            end else if (held && !s_ready) begin
               held = 1'b0;
            end
         end
         if (tx_send === 1'b1) begin
            sent_q.push_back(tx_data);
            scyc.push_back(cyc);
         end
         chk("rx_ack", rx_ack, m_ack);
         chk("tx_send", tx_send, m_send);
         chk("tx_data", tx_data, m_txd);
         chk("count", count, mq.size());
         chk("overflow", overflow, m_ovf);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      int n;
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rx_ack !== 1'b1 && n < 4);
      chk("ack_seen", rx_ack, 1'b1);
      repeat (hold) @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_empty(input int lim);
      int n;
      n = 0;
      while (count != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("drain_bound", (n < lim), 1'b1);
      repeat (40) @(negedge clk);
   endtask

   logic [7:0] arr[17];
   int acks;

   initial begin
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_send", tx_send, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_ack", rx_ack, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single byte, transmitter idle
      rx_data  = 8'h41;
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t1_ack", rx_ack, 1);
      chk("t1_count1", count, 1);
      rx_ready = 1'b0;
      @(negedge clk);
      chk("t1_send", tx_send, 1);
      chk("t1_txd", tx_data, 8'h41);
      chk("t1_count0", count, 0);
      repeat (25) @(negedge clk);

      // burst of five while busy, then ordered drain
      bmode  = 0;
      bforce = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
      @(negedge clk);
      chk("t2_count", count, 5);
      #1;
      chk("t2_model", mq.size(), 5);
      sent_q.delete();
      bmode = 1;
      wait_empty(500);
      chk("t2_nsent", sent_q.size(), 5);
      for (int i = 0; i < 5 && i < sent_q.size(); i++)
         chk("t2_order", sent_q[i], 8'(i + 1));

      // overflow with TX stalled
      do_reset();
      bmode  = 0;
      bforce = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         arr[i] = 8'($urandom);
         send_byte(arr[i], 0);
      end
      @(negedge clk);
      chk("t3_count", count, 16);
      chk("t3_ovf", overflow, 1);
      sent_q.delete();
      bmode = 1;
      wait_empty(1000);
      chk("t3_nsent", sent_q.size(), 16);
      for (int i = 0; i < 16 && i < sent_q.size(); i++)
         chk("t3_data", sent_q[i], xf(arr[i]));
      chk("t3_ovf_sticky", overflow, 1);

      // reset mid-burst
      bmode  = 0;
      bforce = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      @(negedge clk);
      chk("t6_count3", count, 3);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_count", count, 0);
      chk("t6_send", tx_send, 0);
      chk("t6_ovf", overflow, 0);
      reset = 1'b0;

      // rx_ready stuck high
      repeat (2) @(negedge clk);
      rx_data  = 8'hAA;
      rx_ready = 1'b1;
      acks = 0;
      repeat (20) begin
         @(negedge clk);
         if (rx_ack === 1'b1) acks++;
      end
      rx_ready = 1'b0;
      chk("t4_acks", acks, 1);
      chk("t4_count", count, 1);

      // busy never rises: timeout pacing
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      @(negedge clk);
      chk("t5_count", count, 4);
      scyc.delete();
      bmode = 2;
      wait_empty(300);
      chk("t5_nsend", scyc.size(), 4);
      for (int i = 1; i < scyc.size(); i++)
         chk("t5_gap", scyc[i] - scyc[i-1], BT + 2);

`ifdef UART_ECHO_UPPERCASE_EN
      sent_q.delete();
      send_byte(8'h62, 0);
      send_byte(8'h7B, 0);
      wait_empty(300);
      chk("uc_n", sent_q.size(), 2);
      if (sent_q.size() == 2) begin
         chk("uc_lower", sent_q[0], 8'h42);
         chk("uc_brace", sent_q[1], 8'h7B);
      end
`endif

      // randomized traffic
      do_reset();
      bmode = 1;
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            bmode  = $urandom_range(0, 2);
            bforce = 1'b1;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_byte(8'($urandom), $urandom_range(0, 3));
      end
      bmode = 1;
      wait_empty(2000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
